idli_wb_m: RTL and testbench

Write-back unit for the 8x16b rotating general-purpose register file. It accepts a 16b result as four 4b slices, least-significant slice first, over a valid/ready handshake, and buffers the result. It then drives one slice per cycle into the register file's write port, aligned to the file's 4-cycle rotation phase. It sits between the execute datapath and the register file, on the write side opposite the B/C read ports.

---
 rtl/idli_wb_m.sv | 108 ++++++++++
 tb/tb_idli_wb_m.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/idli_wb_m.sv
// idli write-back unit: collects a 16b result as four 4b slices, then
// writes it back one slice per cycle, aligned to the register file rotation.
package idli_pkg;
  typedef logic [2:0] greg_t;
  typedef logic [3:0] sqi_data_t;
endpackage

module idli_wb_m
  import idli_pkg::*;
(
  input  logic      i_wb_gck,
  input  logic      i_wb_rst,
  input  logic      i_wb_vld,
  output logic      o_wb_rdy,
  input  greg_t     i_wb_reg,
  input  sqi_data_t i_wb_data,
  output logic [1:0] o_wb_phase,
  output logic      o_wb_wr_en,
  output greg_t     o_wb_wr_reg,
  output sqi_data_t o_wb_wr_data,
  output logic      o_wb_busy,
  output logic      o_wb_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ALIGN,
    ST_WRITE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  phase;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic [15:0] data_buf;
  greg_t       reg_q;
  logic        take;
  logic        rdy;
  logic        wr;

  assign rdy  = (state == ST_IDLE) || (state == ST_COLLECT);
  assign take = i_wb_vld && rdy;
  assign wr   = (state == ST_WRITE);

  always_ff @(posedge i_wb_gck or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state    <= ST_IDLE;
      phase    <= 2'd0;
      cnt      <= 2'd0;
      data_buf <= 16'h0000;
      reg_q    <= '0;
    end else begin
      phase <= phase + 2'd1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        data_buf[{cnt, 2'b00} +: 4] <= i_wb_data;
      end
      if (take && (state == ST_IDLE)) begin
        reg_q <= i_wb_reg;
      end
    end
  end

  // The slice count wraps to 0 on the 4th slice, ready for the next result.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (take) begin
          cnt_nxt   = 2'd1;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (take) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nxt = (phase == 2'd3) ? ST_WRITE : ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        if (phase == 2'd3) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (phase == 2'd3) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_wb_rdy     = rdy;
  assign o_wb_busy    = (state != ST_IDLE);
  assign o_wb_phase   = phase;
  assign o_wb_wr_en   = wr;
  assign o_wb_wr_reg  = wr ? reg_q : '0;
  assign o_wb_wr_data = wr ? data_buf[{phase, 2'b00} +: 4] : '0;
  assign o_wb_done    = wr && (phase == 2'd3);

endmodule

// File: tb/tb_idli_wb_m.sv
// Directed bench for idli_wb_m with a rotating register file model.
`timescale 1ns/1ps
module tb_idli_wb_m;
  logic       clk;
  logic       rst;
  logic       vld;
  logic       rdy;
  logic [2:0] wreg;
  logic [3:0] data;
  logic [1:0] phase;
  logic       wr_en;
  logic [2:0] wr_reg;
  logic [3:0] wr_data;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  logic [1:0]  ph;
  logic [15:0] rf [8];

  idli_wb_m dut (
    .i_wb_gck    (clk),
    .i_wb_rst    (rst),
    .i_wb_vld    (vld),
    .o_wb_rdy    (rdy),
    .i_wb_reg    (wreg),
    .i_wb_data   (data),
    .o_wb_phase  (phase),
    .o_wb_wr_en  (wr_en),
    .o_wb_wr_reg (wr_reg),
    .o_wb_wr_data(wr_data),
    .o_wb_busy   (busy),
    .o_wb_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ph <= 2'd0;
    else     ph <= ph + 2'd1;
  end

  // Net effect of four rotated inserts: slice p lands in bits [4p+3:4p].
  always @(posedge clk) begin
    if (!rst && wr_en) rf[wr_reg][{ph, 2'b00} +: 4] <= wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(input logic [1:0] p);
    for (int i = 0; i < 4 && ph != p; i++) step();
  endtask

  task automatic send4(input logic [2:0] r, input logic [15:0] v);
    logic [15:0] t;
    t = v;
    for (int k = 0; k < 4; k++) begin
      vld  = 1'b1;
      wreg = r;
      data = t[k*4 +: 4];
      step();
    end
    vld = 1'b0;
  endtask

  task automatic wait_write(input int exp_align);
    int n;
    n = 0;
    while (!wr_en && n < 8) begin
      chk("align_rdy", {31'd0, rdy}, 32'd0);
      step();
      n++;
    end
    chk("align_len", n, exp_align);
  endtask

  task automatic expect_write(input logic [2:0] r, input logic [15:0] v);
    logic [15:0] t;
    t = v;
    for (int p = 0; p < 4; p++) begin
      chk("wr_en", {31'd0, wr_en}, 32'd1);
      chk("wr_phase", {30'd0, phase}, p);
      chk("wr_reg", {29'd0, wr_reg}, {29'd0, r});
      chk("wr_data", {28'd0, wr_data}, {28'd0, t[p*4 +: 4]});
      chk("wr_done", {31'd0, done}, (p == 3) ? 32'd1 : 32'd0);
      chk("wr_rdy", {31'd0, rdy}, 32'd0);
      step();
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_reg"}, {29'd0, wr_reg}, 32'd0);
    chk({tag, "_wr_data"}, {28'd0, wr_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_phase"}, {30'd0, phase}, 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    vld  = 1'b0;
    wreg = 3'd0;
    data = 4'd0;
    #1;
    chk_reset_outs("rst");
    step();
    step();
    rst = 1'b0;

    // Free-running phase while idle
    for (int i = 0; i < 5; i++) begin
      chk("idle_phase", {30'd0, phase}, i % 4);
      chk("idle_rdy", {31'd0, rdy}, 32'd1);
      chk("idle_wr_en", {31'd0, wr_en}, 32'd0);
      step();
    end

    // Last slice accepted in phase 3: write starts next cycle
    wait_ph(2'd0);
    send4(3'd5, 16'h1234);
    wait_write(0);
    expect_write(3'd5, 16'h1234);
    chk("rf_r5", rf[5], 32'h1234);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Last slice accepted in phase 0: three align cycles
    wait_ph(2'd1);
    send4(3'd3, 16'h1234);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    wait_write(3);
    expect_write(3'd3, 16'h1234);
    chk("rf_r3", rf[3], 32'h1234);

    // 0xBEEF to r7 with 2-cycle gaps; next transaction held on vld
    wait_ph(2'd0);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] v;
      v    = 16'hBEEF;
      vld  = 1'b1;
      wreg = 3'd7;
      data = v[k*4 +: 4];
      step();
      if (k < 3) begin
        vld  = 1'b0;
        data = 4'hA;
        step();
        chk("gap_rdy", {31'd0, rdy}, 32'd1);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        step();
      end
    end
    vld  = 1'b1;
    wreg = 3'd0;
    data = 4'h1;
    wait_write(2);
    expect_write(3'd7, 16'hBEEF);
    chk("rf_r7", rf[7], 32'hBEEF);
    chk("t4_rdy_after_done", {31'd0, rdy}, 32'd1);
    chk("t4_phase", {30'd0, phase}, 32'd0);
    step();
    data = 4'h0;
    step();
    step();
    step();
    vld = 1'b0;
    wait_write(0);
    expect_write(3'd0, 16'h0001);
    chk("rf_r0", rf[0], 32'h0001);
    chk("rf_r7_kept", rf[7], 32'hBEEF);

    // Reset during WRITE phase 1
    wait_ph(2'd0);
    send4(3'd2, 16'hA5C3);
    wait_write(0);
    step();
    chk("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
    chk("pre_rst_phase", {30'd0, phase}, 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
